// File: rtl/serial_mag_rx_if.sv
// -----------------------------------------------------------------------------
// serial_mag_rx_if
// Bundles the two-wire magnitude link and the deserialized word outputs of
// serial_mag_rx.
//   next_data  : word-start strobe, high during the bit period of the word MSB
//   data       : serial data bit, MSB first (mag1 then mag2)
//   mag1/mag2  : magnitudes of the last completed word
//   valid      : one-cycle pulse, outputs are new this cycle
//   bin_idx    : bin number of the word presented with valid
//   frame_done : pulse with valid for the last bin of an FFT block
//   sync_err   : pulse when a strobe interrupts an incomplete word
// Modports: master drives the link and observes results (DSP side / bench),
//           slave is the receiver.
// -----------------------------------------------------------------------------
interface serial_mag_rx_if #(
    parameter int WIDTH = 12,
    parameter int BIN_W = 4
) ();
    logic             next_data;
    logic             data;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             valid;
    logic [BIN_W-1:0] bin_idx;
    logic             frame_done;
    logic             sync_err;

    modport master (
        output next_data, data,
        input  mag1, mag2, valid, bin_idx, frame_done, sync_err
    );

    modport slave (
        input  next_data, data,
        output mag1, mag2, valid, bin_idx, frame_done, sync_err
    );
endinterface

// File: rtl/serial_mag_rx.sv
// -----------------------------------------------------------------------------
// serial_mag_rx
// Receive-side deserializer for the two-wire magnitude link. Each strobed
// 2*WIDTH-bit word is split into two WIDTH-bit FFT magnitudes and tagged with
// its bin index within the FFT block. Runs in the bit-clock domain.
// Ports:
//   clk     : bit clock, one serial bit per rising edge
//   reset_n : asynchronous active-low reset
//   bus     : serial_mag_rx_if.slave (link inputs, registered word outputs)
// BIN_W must equal clog2(BINS).
// -----------------------------------------------------------------------------
module serial_mag_rx #(
    parameter int WIDTH    = 12,
    parameter int BINS     = 16,
    parameter int BIN_W    = 4,
    parameter int IDLE_GAP = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_mag_rx_if.slave bus
);
    localparam int WORD  = 2 * WIDTH;
    localparam int CNT_W = $clog2(WORD);
    localparam int GAP_W = $clog2(IDLE_GAP);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(IDLE_GAP - 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BINS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Only the first WORD-1 bits are stored; bit 0 is taken straight from the
    // line on the completing edge.
    logic [WORD-2:0]  shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] mag1_q, mag1_d;
    logic [WIDTH-1:0] mag2_q, mag2_d;
    logic [BIN_W-1:0] bin_idx_q, bin_idx_d;
    logic             valid_q, valid_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;
    logic [WORD-1:0]  word_full;

    assign word_full = {shift_q, bus.data};

    // Next-state logic. A strobe always starts a fresh word from the current
    // bit, whether we are idle, in the inter-word gap, or mid-word (framing
    // error). Completion loads the output registers so valid appears one
    // cycle after bit 0, while the next word's MSB may already be captured.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        bin_d        = bin_q;
        mag1_d       = mag1_q;
        mag2_d       = mag2_q;
        bin_idx_d    = bin_idx_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                if (bus.next_data) begin
                    shift_d   = {{(WORD-2){1'b0}}, bus.data};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = SHIFT;
                end else if (state_q == GAP) begin
                    if (gap_cnt_q == GAP_END) begin
                        // Link went quiet: next word begins a new block.
                        bin_d     = '0;
                        gap_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end

            SHIFT: begin
                if (bus.next_data) begin
                    // Partial word dropped; bin counter untouched.
                    sync_err_d = 1'b1;
                    shift_d    = {{(WORD-2){1'b0}}, bus.data};
                    bit_cnt_d  = CNT_W'(1);
                end else if (bit_cnt_q == LAST_BIT) begin
                    mag1_d       = word_full[WORD-1:WIDTH];
                    mag2_d       = word_full[WIDTH-1:0];
                    bin_idx_d    = bin_q;
                    valid_d      = 1'b1;
                    frame_done_d = (bin_q == LAST_BIN);
                    bin_d        = (bin_q == LAST_BIN) ? '0 : bin_q + BIN_W'(1);
                    gap_cnt_d    = '0;
                    state_d      = GAP;
                end else begin
                    shift_d   = {shift_q[WORD-3:0], bus.data};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any word in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            bin_q        <= '0;
            mag1_q       <= '0;
            mag2_q       <= '0;
            bin_idx_q    <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            bin_q        <= bin_d;
            mag1_q       <= mag1_d;
            mag2_q       <= mag2_d;
            bin_idx_q    <= bin_idx_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign bus.mag1       = mag1_q;
    assign bus.mag2       = mag2_q;
    assign bus.bin_idx    = bin_idx_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
endmodule
